alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Multi-cycle command sequencer that drives the 4-bit `alu` from the producer side. It accepts register-level commands over a valid/ready handshake, reads operands from a 4-entry × 4-bit register file and presents them with `Op`/`arit` to the ALU. It then captures the ALU result and flags, writes the destination register and updates a flag register. It sits between the program/microcode front end and the existing combinational ALU.

## Interface
Parameters:
- `NREGS`, 4: register-file depth; fixed by the 2-bit register indices.
- `W`, 4: data width; matches the ALU.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_imm_en` in 1: 1 = load immediate into `cmd_rd`; no ALU operation.
- `cmd_imm` in 4: immediate value.
- `cmd_arit` in 1: 0 = logic group, 1 = arithmetic group.
- `cmd_op` in 2: operation within the group.
- `cmd_ra`, `cmd_rb`, `cmd_rd` in 2 each: source A, source B, destination.
- `alu_a`, `alu_b` out 4: registered operands to the ALU.
- `alu_op` out 2, `alu_arit` out 1: registered operation to the ALU.
- `alu_r` in 4, `alu_z`, `alu_c`, `alu_s` in 1: ALU outputs, combinational.
- `flag_z`, `flag_c`, `flag_s` out 1: flag register.
- `done` out 1: one-cycle pulse when a write-back occurs.
- `rsp_r` out 4: value written back; valid while `done` = 1.

## Operation
- Operation encodings:
  - Logic group: 00 AND, 01 OR, 10 XOR, 11 NOT A.
  - Arithmetic group: 00 A+B, 01 A−B (A + ~B + 1), 10 −A, 11 −B.
- FSM states are IDLE, EXEC and WB.
  - IDLE: `cmd_ready` = 1. A handshake occurs when `cmd_valid` && `cmd_ready`.
    - On a handshake with `cmd_imm_en` = 1, go to WB and latch the immediate.
    - On a handshake with `cmd_imm_en` = 0, go to EXEC. Load `alu_a` ← reg[ra], `alu_b` ← reg[rb], `alu_op`, `alu_arit`, and latch `rd`.
  - EXEC: `cmd_ready` = 0. Sample `alu_r`, `alu_z`, `alu_c`, `alu_s` into holding registers, then go to WB.
  - WB: `cmd_ready` = 0.
    - Write reg[rd], drive `rsp_r`, pulse `done`, then go to IDLE.
    - Flag update rules:
      - Arithmetic op: z, c and s all updated.
      - Logic op: z updated; c and s held, because the ALU leaves them undefined for logic ops.
      - Immediate load: flags unchanged.
- Operands are read in the accept cycle, after the previous write-back has completed. No forwarding is needed and no read-after-write hazard exists.
- `ra` = `rb` = `rd` is legal. The operands are those read before the write.
- `cmd_*` inputs are ignored outside the handshake cycle. A producer holding `cmd_valid` through EXEC/WB is accepted on the next IDLE cycle.

## Timing
- Reset values, taking effect on the first edge with `reset` = 1:
  - State IDLE.
  - All registers 0.
  - `alu_a`, `alu_b`, `alu_op`, `alu_arit` = 0.
  - `flag_z`, `flag_c`, `flag_s` = 0.
  - `done` = 0, `rsp_r` = 0.
  - `cmd_ready` is forced 0 while `reset` = 1.
- Reset during EXEC or WB aborts the command. No register write and no `done` pulse occur.
- Let the handshake occur at edge T.
  - ALU command: EXEC in cycle T+1, write-back and `done` in cycle T+2, `cmd_ready` = 1 again in cycle T+3.
  - Immediate load: `done` in cycle T+1, `cmd_ready` in cycle T+2.
- Throughput: one ALU command per 3 cycles, one immediate per 2 cycles.
- The written register value and the new flags are visible on outputs and reads from the cycle after `done`.

## Structure
- Package `alu_pkg` holds:
  - The operation-code localparams for both groups.
  - The FSM state encoding.
  - The `W` constant.
- Sub-module `alu_ctrl_regfile`:
  - 4 × 4 registers, two combinational read ports, one synchronous write port with write enable.
  - Synchronous reset to 0.
- The ALU itself is instantiated outside `alu_ctrl`, next to it, so both can be tested independently.

## Test plan
- Reset, then `cmd_imm` = 5 → r0 and `cmd_imm` = 3 → r1 → `done` at T+1, `rsp_r` = 5 then 3, flags stay 000.
- With the real ALU attached, ADD r2 = r0 + r1 → `rsp_r` = 1000, z = 0, c = 0, s = 1, `done` exactly at T+2.
- SUB r3 = r0 − r0 (ra = rb = rd = r0 variant included) → r = 0000, z = 1, c = 1, s = 0. Then NEG A on 0000 → r = 0000, c = 1, z = 1.
- AND r0 & r1 (0101 & 0011) after the SUB → r = 0001, z = 0, c and s held at 1 and 0 from the previous op.
- Hold `cmd_valid` high continuously with changing payloads → exactly one accept per 3 cycles, and the payload sampled is the one present at the accept edge.
- Assert `reset` in the EXEC cycle → no `done`, destination register unchanged at 0, `cmd_ready` = 1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: data width, op codes, FSM states.
package alu_pkg;

  localparam int W = 4;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEGA = 2'b10;
  localparam logic [1:0] OP_NEGB = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command handshake, ALU operand/result path and write-back response of alu_ctrl.
interface alu_ctrl_if;
  import alu_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_imm_en;
  logic [W-1:0] cmd_imm;
  logic         cmd_arit;
  logic [1:0]   cmd_op;
  logic [1:0]   cmd_ra;
  logic [1:0]   cmd_rb;
  logic [1:0]   cmd_rd;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic         alu_arit;
  logic [W-1:0] alu_r;
  logic         alu_z;
  logic         alu_c;
  logic         alu_s;

  logic         flag_z;
  logic         flag_c;
  logic         flag_s;
  logic         done;
  logic [W-1:0] rsp_r;

  modport master (
    output cmd_valid, cmd_imm_en, cmd_imm, cmd_arit, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    output alu_r, alu_z, alu_c, alu_s,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_arit,
    input  flag_z, flag_c, flag_s, done, rsp_r
  );

  modport slave (
    input  cmd_valid, cmd_imm_en, cmd_imm, cmd_arit, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    input  alu_r, alu_z, alu_c, alu_s,
    output cmd_ready, alu_a, alu_b, alu_op, alu_arit,
    output flag_z, flag_c, flag_s, done, rsp_r
  );

endinterface

// File: rtl/alu_ctrl_regfile.sv
// NREGS x W register file: two combinational read ports, one synchronous write port.
module alu_ctrl_regfile #(
  parameter int NREGS = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  output logic [W-1:0]             rdata_a,
  output logic [W-1:0]             rdata_b,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [W-1:0]             wdata
);

  logic [W-1:0] regs [NREGS];

  assign rdata_a = regs[ra];
  assign rdata_b = regs[rb];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wdata;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Sequences register-level commands through an external ALU: 3 cycles per ALU op, 2 per immediate.
// cmd_ready is high only in IDLE; a producer holding cmd_valid is taken on the next IDLE cycle.
module alu_ctrl import alu_pkg::*; #(
  parameter int NREGS = 4,
  parameter int W     = 4
) (
  input logic       clk,
  input logic       reset,
  alu_ctrl_if.slave bus
);

  logic [1:0]   state;
  logic [1:0]   rd_q;
  logic [W-1:0] res_q;
  logic         z_q, c_q, s_q;
  logic         imm_q;
  logic [W-1:0] rf_a, rf_b;
  logic         accept;
  logic         wb;

  assign bus.cmd_ready = (state == ST_IDLE) && !reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign wb            = (state == ST_WB) && !reset;
  assign bus.done      = wb;
  assign bus.rsp_r     = res_q;

  alu_ctrl_regfile #(.NREGS(NREGS), .W(W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra      (bus.cmd_ra),
    .rb      (bus.cmd_rb),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (wb),
    .wa      (rd_q),
    .wdata   (res_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_q         <= '0;
      res_q        <= '0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      s_q          <= 1'b0;
      imm_q        <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_op   <= '0;
      bus.alu_arit <= 1'b0;
      bus.flag_z   <= 1'b0;
      bus.flag_c   <= 1'b0;
      bus.flag_s   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q  <= bus.cmd_rd;
            imm_q <= bus.cmd_imm_en;
            if (bus.cmd_imm_en) begin
              res_q <= bus.cmd_imm;
              state <= ST_WB;
            end else begin
              bus.alu_a    <= rf_a;
              bus.alu_b    <= rf_b;
              bus.alu_op   <= bus.cmd_op;
              bus.alu_arit <= bus.cmd_arit;
              state        <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          res_q <= bus.alu_r;
          z_q   <= bus.alu_z;
          c_q   <= bus.alu_c;
          s_q   <= bus.alu_s;
          state <= ST_WB;
        end
        ST_WB: begin
          // Logic ops leave the ALU's carry and sign undefined, so only z moves for them.
          if (!imm_q) begin
            bus.flag_z <= z_q;
            if (bus.alu_arit) begin
              bus.flag_c <= c_q;
              bus.flag_s <= s_q;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 4-bit ALU attached to its operand outputs.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_ctrl_if bus();

  alu_ctrl #(.NREGS(4), .W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU: logic ops drive c=0, s=1 so that a wrongly updated flag is visible.
  logic [4:0] sum;
  always_comb begin
    sum       = 5'd0;
    bus.alu_r = 4'd0;
    bus.alu_c = 1'b0;
    bus.alu_s = 1'b1;
    if (bus.alu_arit) begin
      case (bus.alu_op)
        OP_ADD:  sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        OP_SUB:  sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        OP_NEGA: sum = {1'b0, ~bus.alu_a} + 5'd1;
        default: sum = {1'b0, ~bus.alu_b} + 5'd1;
      endcase
      bus.alu_r = sum[3:0];
      bus.alu_c = sum[4];
      bus.alu_s = sum[3];
    end else begin
      case (bus.alu_op)
        OP_AND:  bus.alu_r = bus.alu_a & bus.alu_b;
        OP_OR:   bus.alu_r = bus.alu_a | bus.alu_b;
        OP_XOR:  bus.alu_r = bus.alu_a ^ bus.alu_b;
        default: bus.alu_r = ~bus.alu_a;
      endcase
    end
    bus.alu_z = (bus.alu_r == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.flag_z, bus.flag_c, bus.flag_s};
  endfunction

  // Issue one command from a negedge where the DUT is idle; returns done/ready latencies.
  task automatic run_cmd(input logic imm_en, input logic [3:0] imm, input logic arit,
                         input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, output int k_done, output int k_rdy,
                         output logic [3:0] rsp);
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_arit   = arit;
    bus.cmd_op     = op;
    bus.cmd_ra     = ra;
    bus.cmd_rb     = rb;
    bus.cmd_rd     = rd;
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_imm    = ~imm;
    bus.cmd_rd     = ~rd;
    k_done = -1;
    k_rdy  = -1;
    rsp    = 4'd0;
    for (int k = 1; k <= 6 && k_rdy < 0; k++) begin
      @(negedge clk);
      if (bus.done && k_done < 0) begin
        k_done = k;
        rsp    = bus.rsp_r;
      end
      if (bus.cmd_ready) k_rdy = k;
    end
  endtask

  task automatic step(input string tag, input logic imm_en, input logic [3:0] imm,
                      input logic arit, input logic [1:0] op, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [1:0] rd,
                      input logic [3:0] exp_r, input logic [2:0] exp_f);
    int k_done, k_rdy;
    logic [3:0] rsp;
    run_cmd(imm_en, imm, arit, op, ra, rb, rd, k_done, k_rdy, rsp);
    chk({tag, " done_lat"}, k_done, imm_en ? 1 : 2);
    chk({tag, " ready_lat"}, k_rdy, imm_en ? 2 : 3);
    chk({tag, " rsp_r"}, rsp, exp_r);
    chk({tag, " zcs"}, flags(), exp_f);
  endtask

  logic [3:0] got_r [4];
  int n_acc, n_done;

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 4'd0;
    bus.cmd_arit   = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_ra     = 2'd0;
    bus.cmd_rb     = 2'd0;
    bus.cmd_rd     = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", bus.cmd_ready, 0);
    chk("rst done", bus.done, 0);
    chk("rst rsp_r", bus.rsp_r, 0);
    chk("rst zcs", flags(), 3'b000);
    chk("rst alu_ab", {bus.alu_a, bus.alu_b}, 8'h00);
    chk("rst op_arit", {bus.alu_op, bus.alu_arit}, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    chk("idle cmd_ready", bus.cmd_ready, 1);

    //   tag          imm imm   arit op       ra    rb    rd    r      zcs
    step("imm r0=5",  1, 4'd5, 0, 2'd0,    2'd0, 2'd0, 2'd0, 4'h5, 3'b000);
    step("imm r1=3",  1, 4'd3, 0, 2'd0,    2'd0, 2'd0, 2'd1, 4'h3, 3'b000);
    step("add r2",    0, 4'd0, 1, OP_ADD,  2'd0, 2'd1, 2'd2, 4'h8, 3'b001);
    step("sub r3",    0, 4'd0, 1, OP_SUB,  2'd0, 2'd0, 2'd3, 4'h0, 3'b110);
    step("nega r3",   0, 4'd0, 1, OP_NEGA, 2'd3, 2'd1, 2'd3, 4'h0, 3'b110);
    step("and r2",    0, 4'd0, 0, OP_AND,  2'd0, 2'd1, 2'd2, 4'h1, 3'b010);
    step("xor r3",    0, 4'd0, 0, OP_XOR,  2'd1, 2'd1, 2'd3, 4'h0, 3'b110);
    step("sub r0 rrr",0, 4'd0, 1, OP_SUB,  2'd0, 2'd0, 2'd0, 4'h0, 3'b110);
    step("imm r2=6",  1, 4'd6, 0, 2'd0,    2'd0, 2'd0, 2'd2, 4'h6, 3'b110);
    step("add r3",    0, 4'd0, 1, OP_ADD,  2'd0, 2'd1, 2'd3, 4'h3, 3'b000);

    // Stream: cmd_valid held high, payload changes every cycle (r0=0, r1=3, r2=6).
    n_acc  = 0;
    n_done = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.done) begin
        if (n_done < 4) got_r[n_done] = bus.rsp_r;
        n_done++;
      end
      if (i < 12) begin
        if (bus.cmd_ready) n_acc++;
        bus.cmd_imm_en = 1'b0;
        bus.cmd_arit   = 1'b1;
        bus.cmd_op     = 2'(i % 4);
        bus.cmd_ra     = 2'(1 + (i % 2));
        bus.cmd_rb     = 2'd0;
        bus.cmd_rd     = 2'd3;
        bus.cmd_valid  = 1'b1;
      end else begin
        bus.cmd_valid  = 1'b0;
      end
    end
    chk("stream accepts", n_acc, 4);
    chk("stream dones", n_done, 4);
    chk("stream r0", got_r[0], 4'h3);
    chk("stream r1", got_r[1], 4'h0);
    chk("stream r2", got_r[2], 4'hD);
    chk("stream r3", got_r[3], 4'h6);
    chk("stream zcs", flags(), 3'b010);

    // Reset asserted during EXEC aborts the command.
    bus.cmd_arit  = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_ra    = 2'd1;
    bus.cmd_rb    = 2'd2;
    bus.cmd_rd    = 2'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("exec cmd_ready", bus.cmd_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort cmd_ready", bus.cmd_ready, 1);
    chk("abort zcs", flags(), 3'b000);
    for (int k = 0; k < 3; k++) begin
      chk("abort no done", bus.done, 0);
      @(negedge clk);
    end
    step("or r0 r3|r3", 0, 4'd0, 0, OP_OR, 2'd3, 2'd3, 2'd0, 4'h0, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
